// File: rtl/phantom_seq_pkg.sv
// Purpose: shared constants for the phantom transaction sequencer (state codes, defaults, counter width).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package phantom_seq_pkg;

    localparam int TIMEOUT_CYCLES_DEF    = 4096;
    localparam int INIT_PULSE_CYCLES_DEF = 2;
    localparam int CNT_W                 = 8;

    // Sequencer states, kept as plain constants so older tools can read them.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FIRE0 = 3'd1;
    localparam logic [2:0] ST_WAIT0 = 3'd2;
    localparam logic [2:0] ST_FIRE1 = 3'd3;
    localparam logic [2:0] ST_WAIT1 = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;

    // Saturating increment for the pass/fail counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/phantom_txn_sequencer_if.sv
// Purpose: bundles the run control, the two AXI-master trigger/status pairs and the result outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = sequencer side, slave = environment side.
interface phantom_txn_sequencer_if;
    import phantom_seq_pkg::*;

    logic             START;
    logic             ABORT;
    logic [7:0]       REPEAT;
    logic             M00_AXI_INIT_AXI_TXN;
    logic             M00_AXI_TXN_DONE;
    logic             M00_AXI_ERROR;
    logic             M01_AXI_INIT_AXI_TXN;
    logic             M01_AXI_TXN_DONE;
    logic             M01_AXI_ERROR;
    logic             BUSY;
    logic             DONE;
    logic             ABORTED;
    logic [CNT_W-1:0] PASS_CNT;
    logic [CNT_W-1:0] FAIL_CNT;
    logic             TIMEOUT_SEEN;
    logic             LAST_FAIL_PORT;

    modport master (
        input  START, ABORT, REPEAT,
        input  M00_AXI_TXN_DONE, M00_AXI_ERROR, M01_AXI_TXN_DONE, M01_AXI_ERROR,
        output M00_AXI_INIT_AXI_TXN, M01_AXI_INIT_AXI_TXN,
        output BUSY, DONE, ABORTED, PASS_CNT, FAIL_CNT, TIMEOUT_SEEN, LAST_FAIL_PORT
    );

    modport slave (
        output START, ABORT, REPEAT,
        output M00_AXI_TXN_DONE, M00_AXI_ERROR, M01_AXI_TXN_DONE, M01_AXI_ERROR,
        input  M00_AXI_INIT_AXI_TXN, M01_AXI_INIT_AXI_TXN,
        input  BUSY, DONE, ABORTED, PASS_CNT, FAIL_CNT, TIMEOUT_SEEN, LAST_FAIL_PORT
    );

endinterface

// File: rtl/phantom_txn_watch.sv
// Purpose: watches the active master: registered DONE edge detect, ERROR sample, per-transaction timeout.
// Latency: completion flagged one cycle after DONE is first sampled high (registered sample).
// Backpressure: none; i_clr re-arms it on the cycle before a wait window opens.
// Ports: ACLK/ARESETN; i_clr (load edge regs, zero counter), i_en (wait window open),
//        i_done/i_error (muxed master status); o_cmpl, o_err, o_timeout.
module phantom_txn_watch import phantom_seq_pkg::*; #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_done,
    input  logic i_error,
    output logic o_cmpl,
    output logic o_err,
    output logic o_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_cnt;
    logic          r_done_cur;
    logic          r_done_prv;
    logic          r_err;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_cnt      <= '0;
            r_done_cur <= 1'b0;
            r_done_prv <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= i_error;
            if (i_clr) begin
                // Load both samples with the current level so a DONE that is
                // already high when the window opens cannot look like an edge.
                r_done_cur <= i_done;
                r_done_prv <= i_done;
                r_cnt      <= '0;
            end else begin
                r_done_prv <= r_done_cur;
                r_done_cur <= i_done;
                if (i_en && (r_cnt != LAST_CNT)) begin
                    r_cnt <= r_cnt + TW'(1);
                end
            end
        end
    end

    assign o_cmpl    = i_en & r_done_cur & ~r_done_prv;
    assign o_err     = r_err;
    assign o_timeout = i_en & (r_cnt == LAST_CNT);

endmodule

// File: rtl/phantom_txn_sequencer.sv
// Purpose: runs REPEAT rounds of M00-then-M01 transactions, tallying pass/fail/timeout results.
// Latency: first INIT one cycle after START is sampled; DONE pulse the cycle after FIN.
// Backpressure: START ignored while BUSY; ABORT ends any run at the next edge.
// Ports: ACLK/ARESETN plain; bus (master modport) carries START/ABORT/REPEAT, both master
//        INIT/DONE/ERROR pairs and BUSY/DONE/ABORTED/PASS_CNT/FAIL_CNT/TIMEOUT_SEEN/LAST_FAIL_PORT.
module phantom_txn_sequencer import phantom_seq_pkg::*; #(
    parameter int TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF,
    parameter int INIT_PULSE_CYCLES = INIT_PULSE_CYCLES_DEF
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    phantom_txn_sequencer_if.master bus
);

    logic [2:0]       r_state;
    logic [3:0]       r_pulse;
    logic [7:0]       r_rounds;
    logic [CNT_W-1:0] r_pass;
    logic [CNT_W-1:0] r_fail;
    logic             r_timeout_seen;
    logic             r_last_fail_port;
    logic             r_aborted;
    logic             r_done;

    logic w_sel;
    logic w_fire;
    logic w_wait;
    logic w_pulse_last;
    logic w_clr;
    logic w_cmpl;
    logic w_err;
    logic w_timeout;
    logic w_active;

    // Port 1 is selected from FIRE1 on, so the watcher re-arms on the right DONE.
    assign w_sel        = (r_state == ST_FIRE1) || (r_state == ST_WAIT1);
    assign w_fire       = (r_state == ST_FIRE0) || (r_state == ST_FIRE1);
    assign w_wait       = (r_state == ST_WAIT0) || (r_state == ST_WAIT1);
    assign w_pulse_last = (r_pulse == 4'(INIT_PULSE_CYCLES - 1));
    assign w_clr        = w_fire & w_pulse_last;
    // FIN is excluded so a late ABORT cannot stretch the end-of-run sequence.
    assign w_active     = (r_state != ST_IDLE) && (r_state != ST_FIN);

    phantom_txn_watch #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watch (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .i_clr     (w_clr),
        .i_en      (w_wait),
        .i_done    (w_sel ? bus.M01_AXI_TXN_DONE : bus.M00_AXI_TXN_DONE),
        .i_error   (w_sel ? bus.M01_AXI_ERROR    : bus.M00_AXI_ERROR),
        .o_cmpl    (w_cmpl),
        .o_err     (w_err),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state          <= ST_IDLE;
            r_pulse          <= '0;
            r_rounds         <= '0;
            r_pass           <= '0;
            r_fail           <= '0;
            r_timeout_seen   <= 1'b0;
            r_last_fail_port <= 1'b0;
            r_aborted        <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
            if (w_active && bus.ABORT) begin
                r_state   <= ST_FIN;
                r_aborted <= 1'b1;
                r_pulse   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.START) begin
                            if (bus.REPEAT != 8'd0) begin
                                r_rounds       <= bus.REPEAT;
                                r_pass         <= '0;
                                r_fail         <= '0;
                                r_timeout_seen <= 1'b0;
                                r_aborted      <= 1'b0;
                                r_state        <= ST_FIRE0;
                            end else begin
                                r_state <= ST_FIN;
                            end
                        end
                    end
                    ST_FIRE0, ST_FIRE1: begin
                        if (w_pulse_last) begin
                            r_pulse <= '0;
                            r_state <= (r_state == ST_FIRE0) ? ST_WAIT0 : ST_WAIT1;
                        end else begin
                            r_pulse <= r_pulse + 4'd1;
                        end
                    end
                    ST_WAIT0, ST_WAIT1: begin
                        // A completion edge in the timeout cycle still counts as a completion.
                        if (w_cmpl || w_timeout) begin
                            if (w_cmpl && !w_err) begin
                                r_pass <= sat_inc(r_pass);
                            end else begin
                                r_fail           <= sat_inc(r_fail);
                                r_last_fail_port <= w_sel;
                            end
                            if (!w_cmpl) begin
                                r_timeout_seen <= 1'b1;
                            end
                            r_state <= (r_state == ST_WAIT0) ? ST_FIRE1 : ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        r_rounds <= r_rounds - 8'd1;
                        r_state  <= (r_rounds == 8'd1) ? ST_FIN : ST_FIRE0;
                    end
                    ST_FIN:  r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // INIT is decoded from the state, so the two pulses can never overlap.
    assign bus.M00_AXI_INIT_AXI_TXN = (r_state == ST_FIRE0);
    assign bus.M01_AXI_INIT_AXI_TXN = (r_state == ST_FIRE1);
    assign bus.BUSY                 = (r_state != ST_IDLE);
    assign bus.DONE                 = r_done;
    assign bus.ABORTED              = r_aborted;
    assign bus.PASS_CNT             = r_pass;
    assign bus.FAIL_CNT             = r_fail;
    assign bus.TIMEOUT_SEEN         = r_timeout_seen;
    assign bus.LAST_FAIL_PORT       = r_last_fail_port;

endmodule

// File: tb/tb_phantom_txn_sequencer.sv
// Purpose: self-checking bench for phantom_txn_sequencer with behavioural master responders.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_phantom_txn_sequencer;
    import phantom_seq_pkg::*;

    localparam int TO = 64;
    localparam int PW = 2;
    localparam int K_PASS = 0;
    localparam int K_ERR  = 1;
    localparam int K_HANG = 2;

    typedef struct {
        int port;
        int kind;
        int dly;
    } ent_t;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic m_done [2];
    logic m_err  [2];

    phantom_txn_sequencer_if bus ();

    assign bus.M00_AXI_TXN_DONE = m_done[0];
    assign bus.M00_AXI_ERROR    = m_err[0];
    assign bus.M01_AXI_TXN_DONE = m_done[1];
    assign bus.M01_AXI_ERROR    = m_err[1];

    phantom_txn_sequencer #(.TIMEOUT_CYCLES(TO), .INIT_PULSE_CYCLES(PW)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q0[$];
    ent_t q1[$];
    ent_t plan[$];
    int   exp_lfp = 0;
    int   width_bad = 0;
    int   dual_high = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input int port, input int kind, input int dly);
        ent_t e;
        e.port = port; e.kind = kind; e.dly = dly;
        plan.push_back(e);
        if (port == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Master model: on each INIT rising edge take the next scripted behaviour.
    task automatic responder(input int p);
        logic prev;
        logic cur;
        ent_t e;
        prev = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            cur = (p == 0) ? bus.M00_AXI_INIT_AXI_TXN : bus.M01_AXI_INIT_AXI_TXN;
            if (cur && !prev && ((p == 0) ? (q0.size() > 0) : (q1.size() > 0))) begin
                e = (p == 0) ? q0.pop_front() : q1.pop_front();
                if (e.kind != K_HANG) begin
                    m_done[p] = 1'b0; m_err[p] = 1'b0;
                    repeat (e.dly) @(posedge ACLK);
                    #1;
                    m_done[p] = 1'b1; m_err[p] = (e.kind == K_ERR);
                    repeat (3) @(posedge ACLK);
                    #1;
                    m_done[p] = 1'b0; m_err[p] = 1'b0;
                end
            end
            prev = cur;
        end
    endtask

    initial responder(0);
    initial responder(1);

    // INIT pulse width and exclusivity monitor.
    initial begin
        int l0;
        int l1;
        l0 = 0; l1 = 0;
        forever begin
            @(posedge ACLK); #1;
            if (bus.M00_AXI_INIT_AXI_TXN && bus.M01_AXI_INIT_AXI_TXN) dual_high++;
            if (bus.M00_AXI_INIT_AXI_TXN) l0++;
            else begin if (l0 != 0 && l0 != PW) width_bad++; l0 = 0; end
            if (bus.M01_AXI_INIT_AXI_TXN) l1++;
            else begin if (l1 != 0 && l1 != PW) width_bad++; l1 = 0; end
        end
    end

    // Run the queued plan; the expected tallies come from the plan alone.
    // A master answers in time iff its DONE is first sampled after the wait
    // window opens and no later than its last cycle: PW <= dly <= PW+TO-2.
    task automatic run_seq(input string tag, input int rep, input bit with_abort);
        int ep, ef, ets, w0, d0, cyc;
        bit seen, ok;
        ep = 0; ef = 0; ets = 0;
        foreach (plan[i]) begin
            ok = (plan[i].kind != K_HANG) && (plan[i].dly >= PW) && (plan[i].dly <= PW + TO - 2);
            if (ok && plan[i].kind == K_PASS) ep = (ep < 255) ? ep + 1 : 255;
            else begin
                ef = (ef < 255) ? ef + 1 : 255;
                exp_lfp = plan[i].port;
                if (!ok) ets = 1;
            end
        end
        plan.delete();
        w0 = width_bad; d0 = dual_high;
        @(negedge ACLK);
        bus.START = 1'b1; bus.REPEAT = rep[7:0]; bus.ABORT = with_abort;
        @(posedge ACLK); #1;
        bus.START = 1'b0; bus.ABORT = 1'b0;
        chk({tag, "_init_latency"}, bus.M00_AXI_INIT_AXI_TXN, 1);
        if (with_abort) chk({tag, "_aborted_clr"}, bus.ABORTED, 0);
        seen = 0; cyc = 0;
        while (!seen && cyc < rep * 200 + 100) begin
            @(posedge ACLK); #1;
            cyc++;
            // A second START mid-run must be ignored.
            bus.START = (cyc == 5);
            bus.REPEAT = (cyc == 5) ? 8'd7 : rep[7:0];
            if (bus.DONE) seen = 1;
        end
        bus.START = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_pass"}, bus.PASS_CNT, ep);
        chk({tag, "_fail"}, bus.FAIL_CNT, ef);
        chk({tag, "_timeout"}, bus.TIMEOUT_SEEN, ets);
        chk({tag, "_lfp"}, bus.LAST_FAIL_PORT, exp_lfp);
        chk({tag, "_aborted"}, bus.ABORTED, 0);
        chk({tag, "_busy_at_done"}, bus.BUSY, 0);
        chk({tag, "_init_width"}, width_bad - w0, 0);
        chk({tag, "_init_overlap"}, dual_high - d0, 0);
        @(posedge ACLK); #1;
        chk({tag, "_done_one_cycle"}, bus.DONE, 0);
    endtask

    task automatic flush(input int cycles);
        repeat (cycles) @(posedge ACLK);
        q0.delete(); q1.delete(); plan.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_init0"}, bus.M00_AXI_INIT_AXI_TXN, 0);
        chk({tag, "_init1"}, bus.M01_AXI_INIT_AXI_TXN, 0);
        chk({tag, "_busy"}, bus.BUSY, 0);
        chk({tag, "_done"}, bus.DONE, 0);
        chk({tag, "_aborted"}, bus.ABORTED, 0);
        chk({tag, "_pass"}, bus.PASS_CNT, 0);
        chk({tag, "_fail"}, bus.FAIL_CNT, 0);
        chk({tag, "_timeout"}, bus.TIMEOUT_SEEN, 0);
        chk({tag, "_lfp"}, bus.LAST_FAIL_PORT, 0);
    endtask

    initial begin
        int r, cyc, dcnt;
        bit got;
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.REPEAT = 8'd0;
        m_done[0] = 1'b0; m_done[1] = 1'b0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk_all_zero("reset");
        @(negedge ACLK); ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        // Single round, both pass after 10 cycles.
        add(0, K_PASS, 10); add(1, K_PASS, 10);
        run_seq("single", 1, 0);
        flush(10);

        // Three rounds: M01 errors in round 2, M00 hangs in round 3.
        add(0, K_PASS, 10); add(1, K_PASS, 12);
        add(0, K_PASS, 8);  add(1, K_ERR, 9);
        add(0, K_HANG, 0);  add(1, K_PASS, 7);
        run_seq("mixed", 3, 0);
        flush(10);

        // Stale DONE on M00: no edge means a timeout; a fresh 0->1 passes.
        m_done[0] = 1'b1;
        add(0, K_HANG, 0); add(1, K_PASS, 8);
        run_seq("stale_hold", 1, 0);
        add(0, K_PASS, 20); add(1, K_PASS, 8);
        run_seq("stale_edge", 1, 0);
        flush(10);

        // Completion in the last window cycle wins; one cycle later is a timeout.
        add(0, K_PASS, PW + TO - 2); add(1, K_PASS, 5);
        run_seq("collide", 1, 0);
        flush(10);
        add(0, K_PASS, PW + TO - 1); add(1, K_PASS, 5);
        run_seq("late", 1, 0);
        flush(10);

        // ABORT in the first cycle of the M01 pulse.
        add(0, K_PASS, 5); add(1, K_PASS, 5); add(0, K_PASS, 5); add(1, K_PASS, 5);
        @(negedge ACLK); bus.START = 1'b1; bus.REPEAT = 8'd2;
        @(posedge ACLK); #1; bus.START = 1'b0;
        got = 0; cyc = 0;
        while (!got && cyc < 200) begin
            @(posedge ACLK); #1; cyc++;
            if (bus.M01_AXI_INIT_AXI_TXN) got = 1;
        end
        chk("abort_init1_seen", got, 1);
        bus.ABORT = 1'b1;
        @(posedge ACLK); #1; bus.ABORT = 1'b0;
        chk("abort_init1_low", bus.M01_AXI_INIT_AXI_TXN, 0);
        chk("abort_busy", bus.BUSY, 1);
        @(posedge ACLK); #1;
        chk("abort_done", bus.DONE, 1);
        chk("abort_flag", bus.ABORTED, 1);
        chk("abort_pass", bus.PASS_CNT, 1);
        chk("abort_fail", bus.FAIL_CNT, 0);
        flush(20);

        // ABORT in IDLE alongside START: START wins and clears ABORTED.
        add(0, K_PASS, 6); add(1, K_PASS, 6);
        run_seq("start_abort", 1, 1);
        flush(5);

        // REPEAT=0: straight to FIN, no INIT.
        @(negedge ACLK); bus.START = 1'b1; bus.REPEAT = 8'd0;
        @(posedge ACLK); #1; bus.START = 1'b0;
        chk("rep0_busy", bus.BUSY, 1);
        chk("rep0_no_init0", bus.M00_AXI_INIT_AXI_TXN, 0);
        chk("rep0_done_early", bus.DONE, 0);
        @(posedge ACLK); #1;
        chk("rep0_done", bus.DONE, 1);
        chk("rep0_no_init0b", bus.M00_AXI_INIT_AXI_TXN, 0);
        chk("rep0_no_init1b", bus.M01_AXI_INIT_AXI_TXN, 0);
        @(posedge ACLK); #1;
        chk("rep0_done_one_cycle", bus.DONE, 0);
        flush(5);

        // Saturation: 400 passes into an 8-bit counter.
        for (int i = 0; i < 200; i++) begin
            add(0, K_PASS, $urandom_range(3, 6));
            add(1, K_PASS, $urandom_range(3, 6));
        end
        run_seq("saturate", 200, 0);
        flush(10);

        // Randomized runs.
        for (int n = 0; n < 6; n++) begin
            r = $urandom_range(1, 5);
            for (int i = 0; i < 2 * r; i++) begin
                int k;
                k = $urandom_range(0, 99);
                add(i % 2, (k < 60) ? K_PASS : (k < 85) ? K_ERR : K_HANG, $urandom_range(3, 60));
            end
            run_seq($sformatf("rand%0d", n), r, 0);
            flush(10);
        end

        // Reset in the middle of WAIT1.
        add(0, K_PASS, 5); add(1, K_HANG, 0); add(0, K_PASS, 5); add(1, K_PASS, 5);
        plan.delete();
        @(negedge ACLK); bus.START = 1'b1; bus.REPEAT = 8'd2;
        @(posedge ACLK); #1; bus.START = 1'b0;
        got = 0; cyc = 0;
        while (!got && cyc < 200) begin
            @(posedge ACLK); #1; cyc++;
            if (bus.M01_AXI_INIT_AXI_TXN) got = 1;
        end
        chk("rstmid_init1_seen", got, 1);
        repeat (PW + 3) @(posedge ACLK);
        #1;
        chk("rstmid_busy_before", bus.BUSY, 1);
        @(negedge ACLK); ARESETN = 1'b0;
        @(posedge ACLK); #1;
        chk_all_zero("rstmid");
        exp_lfp = 0;
        @(negedge ACLK); ARESETN = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(posedge ACLK); #1;
            if (bus.DONE) dcnt++;
        end
        chk("rstmid_no_done", dcnt, 0);
        chk("rstmid_idle", bus.BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
